// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control and program-load inputs in, issued instruction word and status out.
// The stage drives the slave side; the controller/testbench drives the master side.
interface instr_fetch_if #(
   parameter int PC_WIDTH = 4
);
   logic                run;
   logic                step;
   logic                load_en;
   logic [PC_WIDTH-1:0] load_addr;
   logic [7:0]          load_data;
   logic [3:0]          memoryFunction;
   logic [3:0]          memoryValue;
   logic [PC_WIDTH-1:0] pc;
   logic                fetch_valid;
   logic                halted;

   modport master (
      output run, step, load_en, load_addr, load_data,
      input  memoryFunction, memoryValue, pc, fetch_valid, halted
   );

   modport slave (
      input  run, step, load_en, load_addr, load_data,
      output memoryFunction, memoryValue, pc, fetch_valid, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: writable program store + PC, issues one word per edge in free-run or per step edge.
// Issued word is visible one edge after run/step_rise is sampled; no backpressure, HALT exits only via reset.
module instr_fetch #(
   parameter int         PROG_DEPTH = 16,
   parameter int         PC_WIDTH   = 4,
   parameter logic [3:0] HALT_OP    = 4'hF
) (
   input logic          clk,
   input logic          rst_n,
   instr_fetch_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t              state;
   logic [7:0]          mem [PROG_DEPTH];
   logic [PC_WIDTH-1:0] pc_r;
   logic [3:0]          func_r;
   logic [3:0]          val_r;
   logic                valid_r;
   logic                halted_r;
   logic                step_q;

   logic                step_rise;
   logic                issue;
   logic [7:0]          word;

   assign step_rise = bus.step & ~step_q;
   assign issue     = (state != HALT) & (bus.run | step_rise);
   assign word      = mem[pc_r];

   assign bus.memoryFunction = func_r;
   assign bus.memoryValue    = val_r;
   assign bus.pc             = pc_r;
   assign bus.fetch_valid    = valid_r;
   assign bus.halted         = halted_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc_r     <= '0;
         func_r   <= '0;
         val_r    <= '0;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
         step_q   <= 1'b0;
         for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
      end else begin
         step_q <= bus.step;

         // Loads only land while the fetch side is quiet, so a write never races a read.
         if (bus.load_en && !issue && state != RUN)
            mem[bus.load_addr] <= bus.load_data;

         case (state)
            HALT: begin
               func_r   <= '0;
               val_r    <= '0;
               valid_r  <= 1'b0;
               halted_r <= 1'b1;
            end
            default: begin
               if (issue) begin
                  if (word[7:4] == HALT_OP) begin
                     func_r   <= '0;
                     val_r    <= '0;
                     valid_r  <= 1'b0;
                     halted_r <= 1'b1;
                     state    <= HALT;
                  end else begin
                     func_r  <= word[7:4];
                     val_r   <= word[3:0];
                     valid_r <= 1'b1;
                     pc_r    <= pc_r + 1'b1;
                     state   <= bus.run ? RUN : IDLE;
                  end
               end else begin
                  func_r  <= '0;
                  val_r   <= '0;
                  valid_r <= 1'b0;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, all checked against a behavioural model.
module tb_instr_fetch;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   instr_fetch_if #(.PC_WIDTH(4)) bus ();

   instr_fetch #(.PROG_DEPTH(16), .PC_WIDTH(4), .HALT_OP(4'hF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: program image, pc, mode flags and expected outputs.
   logic [7:0] m_mem [16];
   int         m_pc;
   bit         m_halted;
   bit         m_running;
   bit         m_step_prev;
   int         e_f;
   int         e_v;
   bit         e_fv;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r_n, input bit rn, input bit st, input bit le,
                             input logic [3:0] la, input logic [7:0] ld);
      bit rise;
      logic [7:0] w;
      if (!r_n) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
         m_pc = 0; m_halted = 0; m_running = 0; m_step_prev = 0;
         e_f = 0; e_v = 0; e_fv = 0;
         return;
      end
      rise = st && !m_step_prev;
      m_step_prev = st;
      if (m_halted) begin
         if (le) m_mem[la] = ld;
         e_f = 0; e_v = 0; e_fv = 0;
      end else if (rn || rise) begin
         w = m_mem[m_pc];
         if (w[7:4] == 4'hF) begin
            m_halted = 1; m_running = 0;
            e_f = 0; e_v = 0; e_fv = 0;
         end else begin
            e_f = w[7:4]; e_v = w[3:0]; e_fv = 1;
            m_pc = (m_pc + 1) % 16;
            m_running = rn;
         end
      end else begin
         if (le && !m_running) m_mem[la] = ld;
         e_f = 0; e_v = 0; e_fv = 0;
         m_running = 0;
      end
   endtask

   // One clock: drive inputs, advance model, then compare every output #1 after the edge.
   task automatic tick(input bit r_n, input bit rn, input bit st, input bit le,
                       input logic [3:0] la, input logic [7:0] ld);
      rst_n = r_n; bus.run = rn; bus.step = st; bus.load_en = le;
      bus.load_addr = la; bus.load_data = ld;
      model_edge(r_n, rn, st, le, la, ld);
      @(posedge clk);
      #1;
      chk("m_func",   int'(bus.memoryFunction), e_f);
      chk("m_value",  int'(bus.memoryValue),    e_v);
      chk("m_valid",  int'(bus.fetch_valid),    int'(e_fv));
      chk("m_pc",     int'(bus.pc),             m_pc);
      chk("m_halted", int'(bus.halted),         int'(m_halted));
   endtask

   task automatic idle_load(input logic [3:0] a, input logic [7:0] d);
      tick(1, 0, 0, 1, a, d);
   endtask

   initial begin
      int n;
      checks = 0;
      failures = 0;

      // Reset, then run through a short program ending in HALT.
      tick(0, 0, 0, 0, 4'd0, 8'h00);
      tick(0, 0, 0, 0, 4'd0, 8'h00);
      chk("rst_pc", int'(bus.pc), 0);
      chk("rst_valid", int'(bus.fetch_valid), 0);
      chk("rst_halted", int'(bus.halted), 0);
      idle_load(4'd0, 8'h13);
      idle_load(4'd1, 8'h25);
      idle_load(4'd2, 8'h31);
      idle_load(4'd3, 8'hF0);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("run0_f", int'(bus.memoryFunction), 1);
      chk("run0_v", int'(bus.memoryValue), 3);
      chk("run0_pc", int'(bus.pc), 1);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("run1_fv", int'({bus.memoryFunction, bus.memoryValue}), 8'h25);
      chk("run1_pc", int'(bus.pc), 2);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("run2_fv", int'({bus.memoryFunction, bus.memoryValue}), 8'h31);
      chk("run2_valid", int'(bus.fetch_valid), 1);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("halt_valid", int'(bus.fetch_valid), 0);
      chk("halt_halted", int'(bus.halted), 1);
      chk("halt_pc", int'(bus.pc), 3);
      tick(1, 0, 1, 0, 4'd0, 8'h00);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      tick(1, 0, 1, 0, 4'd0, 8'h00);
      chk("halt_frozen_pc", int'(bus.pc), 3);
      chk("halt_frozen_h", int'(bus.halted), 1);
      tick(0, 0, 0, 0, 4'd0, 8'h00);
      chk("halt_rst_h", int'(bus.halted), 0);
      chk("halt_rst_pc", int'(bus.pc), 0);

      // Single step: held step issues once, a fresh rising edge issues the next.
      idle_load(4'd0, 8'h17);
      idle_load(4'd1, 8'h42);
      tick(1, 0, 1, 0, 4'd0, 8'h00);
      chk("step0_fv", int'({bus.memoryFunction, bus.memoryValue}), 8'h17);
      chk("step0_pc", int'(bus.pc), 1);
      for (int i = 0; i < 4; i++) tick(1, 0, 1, 0, 4'd0, 8'h00);
      chk("step_held_pc", int'(bus.pc), 1);
      chk("step_held_valid", int'(bus.fetch_valid), 0);
      tick(1, 0, 0, 0, 4'd0, 8'h00);
      tick(1, 0, 1, 0, 4'd0, 8'h00);
      chk("step1_fv", int'({bus.memoryFunction, bus.memoryValue}), 8'h42);
      chk("step1_pc", int'(bus.pc), 2);

      // Run/stop bubble: valid 1,1,0,1,1 with pc 1,2,2,3,4.
      tick(0, 0, 0, 0, 4'd0, 8'h00);
      for (int i = 0; i < 6; i++) idle_load(4'(i), {4'(i + 1), 4'(i)});
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("bub_pc_a", int'(bus.pc), 2);
      tick(1, 0, 0, 0, 4'd0, 8'h00);
      chk("bub_gap_valid", int'(bus.fetch_valid), 0);
      chk("bub_gap_pc", int'(bus.pc), 2);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("bub_resume_f", int'(bus.memoryFunction), 3);
      chk("bub_resume_pc", int'(bus.pc), 3);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("bub_next_pc", int'(bus.pc), 4);

      // Wrap: 18 issues from pc 0 pass 15 -> 0 -> 1 with no gap.
      tick(0, 0, 0, 0, 4'd0, 8'h00);
      for (int i = 0; i < 16; i++) idle_load(4'(i), 8'h11);
      for (int k = 1; k <= 18; k++) begin
         tick(1, 1, 0, 0, 4'd0, 8'h00);
         chk("wrap_valid", int'(bus.fetch_valid), 1);
         if (k == 16) chk("wrap_pc16", int'(bus.pc), 0);
         if (k == 17) chk("wrap_pc17", int'(bus.pc), 1);
      end

      // Load gating: a write during RUN is dropped, the same write in IDLE lands.
      tick(1, 1, 0, 1, 4'd2, 8'h5A);
      for (int i = 0; i < 15; i++) tick(1, 1, 0, 0, 4'd0, 8'h00);
      tick(1, 1, 0, 0, 4'd0, 8'h00);
      chk("gate_run_old", int'({bus.memoryFunction, bus.memoryValue}), 8'h11);
      tick(1, 0, 0, 0, 4'd0, 8'h00);
      idle_load(4'd2, 8'h5A);
      n = 0;
      while (m_pc != 2 && n < 40) begin
         tick(1, 0, 1, 0, 4'd0, 8'h00);
         tick(1, 0, 0, 0, 4'd0, 8'h00);
         n++;
      end
      chk("gate_step_budget", int'(n < 40), 1);
      chk("gate_reach_pc", int'(bus.pc), 2);
      tick(1, 0, 1, 0, 4'd0, 8'h00);
      chk("gate_idle_new", int'({bus.memoryFunction, bus.memoryValue}), 8'h5A);

      // Random traffic, including occasional resets and HALT words.
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(39) != 0,
              $urandom_range(2) != 0,
              $urandom_range(1) != 0,
              $urandom_range(2) == 0,
              4'($urandom_range(15)),
              8'($urandom_range(255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
